arm_multicycle_ctrl: RTL and testbench

- Main sequencer for the multicycle ARM-subset datapath: a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback.
- Drives mux selects, ALU control and all architectural write enables.
- Write enables are gated by the condition-check result CondEx and by instruction class.
- Sits between the instruction register and the shared datapath. The external condition checker and flag registers consume FlagWrite.

---
 rtl/arm_multicycle_ctrl_if.sv | 34 +++
 rtl/arm_multicycle_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_arm_multicycle_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_multicycle_ctrl_if.sv
// Control bundle between the multicycle ARM sequencer and the shared datapath.
// master = controller side, slave = datapath / instruction register side.
interface arm_multicycle_ctrl_if #(
  parameter int STATE_W = 4
);
  logic [1:0]         Op;
  logic [5:0]         Funct;
  logic [3:0]         Rd;
  logic               CondEx;
  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic [1:0]         ResultSrc;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUControl;
  logic [1:0]         FlagWrite;
  logic               Illegal;
  logic [STATE_W-1:0] StateOut;

  modport master (
    input  Op, Funct, Rd, CondEx,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, FlagWrite, Illegal, StateOut
  );

  modport slave (
    output Op, Funct, Rd, CondEx,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, FlagWrite, Illegal, StateOut
  );
endinterface

// File: rtl/arm_multicycle_ctrl.sv
// Moore sequencer for the multicycle ARM-subset datapath (fetch/decode/execute/mem/writeback).
// Optional macro ILLEGAL_TRAP_EN: undefined instructions park the FSM in HALT until reset.
module arm_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  arm_multicycle_ctrl_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    MEMADR = STATE_W'(2),
    MEMRD  = STATE_W'(3),
    MEMWB  = STATE_W'(4),
    MEMWR  = STATE_W'(5),
    EXECR  = STATE_W'(6),
    EXECI  = STATE_W'(7),
    ALUWB  = STATE_W'(8),
    BRANCH = STATE_W'(9),
    HALT   = STATE_W'(10)
  } state_t;

  state_t     r_state;
  logic       r_illegal;

  logic [3:0] w_cmd;
  logic [1:0] w_alu_dec;
  logic       w_cmd_bad;
  logic       w_no_write;
  logic       w_flag_cv;
  logic       w_en;
  logic       w_next_pc;
  logic       w_branch;
  logic       w_reg_w;
  logic       w_mem_w;
  logic       w_ir_write;
  logic       w_alu_op;
  logic       w_flag_st;
  logic       w_adr_src;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_result_src;
  logic       w_fw_nz;

  assign w_cmd      = bus.Funct[4:1];
  assign w_no_write = (w_cmd == 4'b1010);
  assign w_flag_cv  = (w_cmd == 4'b0100) | (w_cmd == 4'b0010) | (w_cmd == 4'b1010);

  always_comb begin
    w_alu_dec = 2'b00;
    w_cmd_bad = 1'b0;
    case (w_cmd)
      4'b0100:          w_alu_dec = 2'b00;
      4'b0010, 4'b1010: w_alu_dec = 2'b01;
      4'b0000:          w_alu_dec = 2'b10;
      4'b1100:          w_alu_dec = 2'b11;
      default:          w_cmd_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        FETCH:  r_state <= DECODE;
        DECODE: begin
          case (bus.Op)
            2'b01:   r_state <= MEMADR;
            2'b00:   r_state <= bus.Funct[5] ? EXECI : EXECR;
            2'b10:   r_state <= BRANCH;
            default: begin
              r_illegal <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
              r_state   <= HALT;
`else
              r_state   <= FETCH;
`endif
            end
          endcase
        end
        MEMADR: r_state <= bus.Funct[0] ? MEMRD : MEMWR;
        MEMRD:  r_state <= MEMWB;
        MEMWB:  r_state <= FETCH;
        MEMWR:  r_state <= FETCH;
        EXECR, EXECI: begin
          r_state <= ALUWB;
          if (w_cmd_bad) begin
            r_illegal <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
            r_state   <= HALT;
`endif
          end
        end
        ALUWB:  r_state <= FETCH;
        BRANCH: r_state <= FETCH;
`ifdef ILLEGAL_TRAP_EN
        HALT:   r_state <= HALT;
`endif
        default: r_state <= FETCH;
      endcase
    end
  end

  // HALT and unused encodings fall through to the all-zero defaults
  always_comb begin
    w_next_pc    = 1'b0;
    w_branch     = 1'b0;
    w_reg_w      = 1'b0;
    w_mem_w      = 1'b0;
    w_ir_write   = 1'b0;
    w_alu_op     = 1'b0;
    w_flag_st    = 1'b0;
    w_adr_src    = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_result_src = 2'b00;
    case (r_state)
      FETCH: begin
        w_ir_write   = 1'b1;
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_next_pc    = 1'b1;
      end
      DECODE: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
      end
      MEMADR: w_alu_src_b = 2'b01;
      MEMRD:  w_adr_src   = 1'b1;
      MEMWB: begin
        w_result_src = 2'b01;
        w_reg_w      = 1'b1;
      end
      MEMWR: begin
        w_adr_src = 1'b1;
        w_mem_w   = 1'b1;
      end
      EXECR: begin
        w_alu_op  = 1'b1;
        w_flag_st = 1'b1;
      end
      EXECI: begin
        w_alu_src_b = 2'b01;
        w_alu_op    = 1'b1;
        w_flag_st   = 1'b1;
      end
      ALUWB: w_reg_w = 1'b1;
      BRANCH: begin
        w_alu_src_b  = 2'b01;
        w_result_src = 2'b10;
        w_branch     = 1'b1;
      end
      default: ;
    endcase
  end

  // Every architectural enable is suppressed while reset is held
  assign w_en    = ~reset;
  assign w_fw_nz = w_en & w_flag_st & bus.Funct[0] & bus.CondEx;

  assign bus.PCWrite    = w_en & (w_next_pc | (w_branch & bus.CondEx) |
                                  (w_reg_w & bus.CondEx & (bus.Rd == 4'hF)));
  assign bus.RegWrite   = w_en & w_reg_w & bus.CondEx & ~((r_state == ALUWB) & w_no_write);
  assign bus.MemWrite   = w_en & w_mem_w & bus.CondEx;
  assign bus.IRWrite    = w_en & w_ir_write;
  assign bus.FlagWrite  = {w_fw_nz, w_fw_nz & w_flag_cv};
  assign bus.AdrSrc     = w_adr_src;
  assign bus.ResultSrc  = w_result_src;
  assign bus.ALUSrcA    = w_alu_src_a;
  assign bus.ALUSrcB    = w_alu_src_b;
  assign bus.ALUControl = w_alu_op ? w_alu_dec : 2'b00;
  assign bus.Illegal    = r_illegal;
  assign bus.StateOut   = r_state;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Randomized bench for arm_multicycle_ctrl: per-instruction state sequences and per-state
// output table built from the instruction class, plus literal checks of the directed cases.
module tb_arm_multicycle_ctrl;
  localparam int STATE_W = 4;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arm_multicycle_ctrl_if #(.STATE_W(STATE_W)) bus ();
  arm_multicycle_ctrl #(.STATE_W(STATE_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_illegal;

  // per-cycle observations of the most recent instruction
  logic [31:0] obs_state [8];
  logic [31:0] obs_regw  [8];
  logic [31:0] obs_pcw   [8];
  logic [31:0] obs_irw   [8];
  logic [31:0] obs_memw  [8];
  logic [31:0] obs_adr   [8];
  logic [31:0] obs_res   [8];
  logic [31:0] obs_alu   [8];
  logic [31:0] obs_fw    [8];
  logic [31:0] obs_ill   [8];

  typedef struct packed {
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] res;
    logic       a;
    logic [1:0] b, alu, fw;
  } outs_t;

  typedef int iq_t[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cmd_ok(logic [3:0] c);
    return (c == 4'd0) || (c == 4'd2) || (c == 4'd4) || (c == 4'd10) || (c == 4'd12);
  endfunction

  function automatic logic [1:0] alu_of(logic [3:0] c);
    case (c)
      4'd2, 4'd10: return 2'd1;
      4'd0:        return 2'd2;
      4'd12:       return 2'd3;
      default:     return 2'd0;
    endcase
  endfunction

  // Expected state walk for one instruction, from its class
  function automatic iq_t seq_of(logic [1:0] op, logic [5:0] funct);
    iq_t q;
    q = '{0, 1};
    case (op)
      2'd1: begin
        q.push_back(2);
        if (funct[0]) begin q.push_back(3); q.push_back(4); end
        else q.push_back(5);
      end
      2'd0: begin
        q.push_back(funct[5] ? 7 : 6);
        q.push_back((TRAP && !cmd_ok(funct[4:1])) ? 10 : 8);
      end
      2'd2: q.push_back(9);
      default: if (TRAP) q.push_back(10);
    endcase
    return q;
  endfunction

  function automatic outs_t model_outs(int st, logic [5:0] funct, logic [3:0] rd,
                                       logic cond, logic rst);
    outs_t o;
    logic [3:0] cmd;
    cmd = funct[4:1];
    o = '0;
    case (st)
      0: begin o.irw = 1; o.a = 1; o.b = 2; o.res = 2; o.pcw = 1; end
      1: begin o.a = 1; o.b = 2; o.res = 2; end
      2: o.b = 1;
      3: o.adr = 1;
      4: begin o.res = 1; o.regw = cond; o.pcw = cond && rd == 15; end
      5: begin o.adr = 1; o.memw = cond; end
      6, 7: begin
        o.b = (st == 7) ? 2'd1 : 2'd0;
        o.alu = alu_of(cmd);
        if (cond && funct[0])
          o.fw = {1'b1, (cmd == 4 || cmd == 2 || cmd == 10)};
      end
      8: begin o.regw = cond && cmd != 10; o.pcw = cond && rd == 15; end
      9: begin o.b = 1; o.res = 2; o.pcw = cond; end
      default: ;
    endcase
    if (rst) begin o.pcw = 0; o.memw = 0; o.irw = 0; o.regw = 0; o.fw = 0; end
    return o;
  endfunction

  // Compares every output of the current cycle against the model
  task automatic compare_cycle(int st, bit know_state, int idx);
    outs_t e;
    string p;
    e = model_outs(st, bus.Funct, bus.Rd, bus.CondEx, reset);
    p = $sformatf("s%0d", st);
    chk({p, "_PCWrite"}, bus.PCWrite, e.pcw);
    chk({p, "_MemWrite"}, bus.MemWrite, e.memw);
    chk({p, "_IRWrite"}, bus.IRWrite, e.irw);
    chk({p, "_RegWrite"}, bus.RegWrite, e.regw);
    chk({p, "_FlagWrite"}, bus.FlagWrite, e.fw);
    if (know_state) begin
      chk({p, "_StateOut"}, bus.StateOut, st);
      chk({p, "_Illegal"}, bus.Illegal, exp_illegal);
      chk({p, "_AdrSrc"}, bus.AdrSrc, e.adr);
      chk({p, "_ResultSrc"}, bus.ResultSrc, e.res);
      chk({p, "_ALUSrcA"}, bus.ALUSrcA, e.a);
      chk({p, "_ALUSrcB"}, bus.ALUSrcB, e.b);
      chk({p, "_ALUControl"}, bus.ALUControl, e.alu);
    end
    if (idx >= 0 && idx < 8) begin
      obs_state[idx] = bus.StateOut;  obs_regw[idx] = bus.RegWrite;
      obs_pcw[idx]   = bus.PCWrite;   obs_irw[idx]  = bus.IRWrite;
      obs_memw[idx]  = bus.MemWrite;  obs_adr[idx]  = bus.AdrSrc;
      obs_res[idx]   = bus.ResultSrc; obs_alu[idx]  = bus.ALUControl;
      obs_fw[idx]    = bus.FlagWrite; obs_ill[idx]  = bus.Illegal;
    end
  endtask

  task automatic do_reset(int cycles, bit first_known);
    @(negedge clk);
    reset = 1'b1;
    bus.Op = 2'($urandom); bus.Funct = 6'($urandom);
    bus.Rd = 4'($urandom); bus.CondEx = 1'b1;
    #1 compare_cycle(0, 1'b0, -1);
    if (first_known) chk("reset_first_Illegal", bus.Illegal, exp_illegal);
    exp_illegal = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      #1 compare_cycle(0, 1'b1, -1);
    end
  endtask

  // Walks one instruction; abort_at >= 0 asserts reset in that cycle of the walk
  task automatic run_instr(logic [1:0] op, logic [5:0] funct, logic [3:0] rd,
                           logic cond, int abort_at);
    iq_t q;
    q = seq_of(op, funct);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        reset = 1'b0;
        bus.Op = op; bus.Funct = funct; bus.Rd = rd; bus.CondEx = cond;
      end
      if (i == abort_at) reset = 1'b1;
      #1 compare_cycle(q[i], 1'b1, i);
      if (i == abort_at) return;
      if ((q[i] == 1 && op == 2'd3) || ((q[i] == 6 || q[i] == 7) && !cmd_ok(funct[4:1])))
        exp_illegal = 1'b1;
    end
    if (q[q.size()-1] == 10) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        #1 compare_cycle(10, 1'b1, -1);
      end
      do_reset(1, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    exp_illegal = 1'b0;
    bus.Op = '0; bus.Funct = '0; bus.Rd = '0; bus.CondEx = 1'b0;
    do_reset(2, 1'b0);

    // ADD reg, S=0
    run_instr(2'b00, 6'b001000, 4'd3, 1'b1, -1);
    chk("add_st2", obs_state[2], 6);
    chk("add_st3", obs_state[3], 8);
    chk("add_irw0", obs_irw[0], 1);
    chk("add_irw3", obs_irw[3], 0);
    chk("add_regw3", obs_regw[3], 1);
    chk("add_fw2", obs_fw[2], 0);

    // CMP imm, S=1
    run_instr(2'b00, 6'b110101, 4'd0, 1'b1, -1);
    chk("cmp_st2", obs_state[2], 7);
    chk("cmp_alu2", obs_alu[2], 1);
    chk("cmp_fw2", obs_fw[2], 3);
    chk("cmp_regw3", obs_regw[3], 0);

    // LDR then STR
    run_instr(2'b01, 6'b000001, 4'd2, 1'b1, -1);
    chk("ldr_st4", obs_state[4], 4);
    chk("ldr_adr3", obs_adr[3], 1);
    chk("ldr_res4", obs_res[4], 1);
    chk("ldr_regw4", obs_regw[4], 1);
    run_instr(2'b01, 6'b000000, 4'd2, 1'b1, -1);
    chk("str_st3", obs_state[3], 5);
    chk("str_memw3", obs_memw[3], 1);
    chk("str_regw3", obs_regw[3], 0);

    // Branch, condition failed then passed
    run_instr(2'b10, 6'b000000, 4'd0, 1'b0, -1);
    chk("b_nc_st2", obs_state[2], 9);
    chk("b_nc_pcw2", obs_pcw[2], 0);
    run_instr(2'b10, 6'b000000, 4'd0, 1'b1, -1);
    chk("b_c_pcw2", obs_pcw[2], 1);

    // ADD to PC, condition passed then failed
    run_instr(2'b00, 6'b001000, 4'd15, 1'b1, -1);
    chk("addpc_pcw3", obs_pcw[3], 1);
    chk("addpc_regw3", obs_regw[3], 1);
    run_instr(2'b00, 6'b001000, 4'd15, 1'b0, -1);
    chk("addpc_nc_pcw3", obs_pcw[3], 0);
    chk("addpc_nc_regw3", obs_regw[3], 0);

    // Undefined instruction
    run_instr(2'b11, 6'b000000, 4'd0, 1'b1, -1);
    if (TRAP) begin
      chk("undef_halt_ill", bus.Illegal, 0);
      chk("undef_halt_st", bus.StateOut, 0);
    end else begin
      chk("undef_ill1", obs_ill[1], 0);
      run_instr(2'b00, 6'b001000, 4'd1, 1'b1, -1);
      chk("undef_next_st0", obs_state[0], 0);
      chk("undef_next_ill", obs_ill[0], 1);
      do_reset(1, 1'b1);
    end

    // Reset in the middle of a store: MemWrite must stay low
    run_instr(2'b01, 6'b000000, 4'd0, 1'b1, 3);
    chk("abort_memw", obs_memw[3], 0);
    do_reset(1, 1'b1);

    for (int n = 0; n < 80; n++) begin
      logic [1:0] op;
      logic [5:0] funct;
      logic [3:0] rd;
      logic       cond;
      op    = 2'($urandom_range(0, 3));
      funct = 6'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: funct[4:1] = 4'd0;
          1: funct[4:1] = 4'd2;
          2: funct[4:1] = 4'd4;
          3: funct[4:1] = 4'd10;
          default: funct[4:1] = 4'd12;
        endcase
      end
      rd   = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom);
      cond = ($urandom_range(0, 3) != 0);
      run_instr(op, funct, rd, cond, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
